// File: rtl/noise_lfsr_gen.sv
// Noise generator: built-in period divider drives a parametrised LFSR with AY, tap-mask, ring and freeze modes.
// Latency: out/lfsr_state update on the shift edge itself; backpressure: none, enable gates all advance.
module noise_lfsr_gen #(
    parameter int LFSR_BITS   = 17,
    parameter int LFSR_TAP0   = 0,
    parameter int LFSR_TAP1   = 3,
    parameter int PERIOD_BITS = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [1:0]             mode,
    input  logic [LFSR_BITS-1:0]   tap_mask,
    input  logic [LFSR_BITS-1:0]   seed,
    input  logic                   restart,
    output logic                   out,
    output logic [LFSR_BITS-1:0]   lfsr_state,
    output logic                   shift_strobe
);

    typedef enum logic [1:0] {
        MODE_AY     = 2'b00,
        MODE_MASK   = 2'b01,
        MODE_RING   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    mode_e                  mode_sel;
    logic [PERIOD_BITS-1:0] counter;
    logic [PERIOD_BITS-1:0] last_count;
    logic                   phase;
    logic [LFSR_BITS-1:0]   lfsr;
    logic [LFSR_BITS-1:0]   lfsr_next;
    logic                   wrap;
    logic                   shift;
    logic                   zero;
    logic                   fb;

    assign mode_sel = mode_e'(mode);

    // A period of 0 behaves as 1; >= lets a shortened period wrap immediately
    // instead of counting through the full register range.
    always_comb begin
        last_count = (period == '0) ? '0 : period - PERIOD_BITS'(1);
        wrap       = (counter >= last_count);
        shift      = enable && wrap && !phase && (mode_sel != MODE_FREEZE);
        zero       = (lfsr == '0);
    end

    always_comb begin
        fb = 1'b0;
        case (mode_sel)
            MODE_AY:   fb = lfsr[LFSR_TAP0] ^ lfsr[LFSR_TAP1];
            MODE_MASK: fb = ^(lfsr & tap_mask);
            MODE_RING: fb = lfsr[0];
            default:   fb = 1'b0;
        endcase
        fb        = fb | zero;
        lfsr_next = {fb, lfsr[LFSR_BITS-1:1]};
    end

    // Restart outranks everything, including enable and a coincident shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter      <= '0;
            phase        <= 1'b0;
            lfsr         <= '0;
            shift_strobe <= 1'b0;
        end else if (restart) begin
            counter      <= '0;
            phase        <= 1'b0;
            lfsr         <= seed;
            shift_strobe <= 1'b0;
        end else begin
            shift_strobe <= shift;
            if (enable) begin
                if (wrap) begin
                    counter <= '0;
                    phase   <= ~phase;
                end else begin
                    counter <= counter + PERIOD_BITS'(1);
                end
            end
            if (shift) begin
                lfsr <= lfsr_next;
            end
        end
    end

    assign out        = ~lfsr[0];
    assign lfsr_state = lfsr;

endmodule
